adc_pulse_emulator: RTL and testbench

//  Synthetic detector-pulse source that drives ADC-format samples into the shaping-filter chain.

---
 rtl/adc_pulse_emulator_if.sv | 24 ++
 rtl/adc_pulse_emulator.sv | 98 +++++++++
 tb/tb_adc_pulse_emulator.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pulse_emulator_if.sv
// Control and sample bus of the pulse emulator: trigger/shape controls in, ADC-format sample out.
interface adc_pulse_emulator_if #(
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 16
);
  logic                enable;
  logic                trig;
  logic [DATA_W-1:0]   amplitude;
  logic [3:0]          decay_shift;
  logic [PERIOD_W-1:0] period;
  logic [DATA_W-1:0]   output_data;
  logic                pulse_start;
  logic                busy;

  modport master (
    output enable, trig, amplitude, decay_shift, period,
    input  output_data, pulse_start, busy
  );

  modport slave (
    input  enable, trig, amplitude, decay_shift, period,
    output output_data, pulse_start, busy
  );
endinterface

// File: rtl/adc_pulse_emulator.sv
// Synthetic detector-pulse source: each trigger adds a step to a fixed-point accumulator that
// decays by acc >> decay_shift per cycle; overlapping triggers pile up and saturate.
module adc_pulse_emulator #(
  parameter int DATA_W   = 12,
  parameter int FRAC_W   = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  adc_pulse_emulator_if.slave bus
);

  localparam int W = DATA_W + FRAC_W;

  typedef enum logic {
    IDLE  = 1'b0,
    DECAY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                pulse_start_q, pulse_start_d;

  logic                auto_fire;
  logic                trig_event;
  logic [W-1:0]        step;
  logic [W:0]          sum;
  logic [W-1:0]        decayed;

  // The >= compare lets a shortened period fire immediately instead of waiting for a wrap.
  always_comb begin
    cnt_d     = '0;
    auto_fire = 1'b0;
    if (bus.enable && (bus.period != '0)) begin
      if (cnt_q >= (bus.period - PERIOD_W'(1))) begin
        auto_fire = 1'b1;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  assign trig_event = (bus.trig | auto_fire) & bus.enable & (bus.amplitude != '0);
  assign step       = {bus.amplitude, {FRAC_W{1'b0}}};
  assign sum        = {1'b0, acc_q} + {1'b0, step};
  assign decayed    = acc_q - (acc_q >> bus.decay_shift);

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    pulse_start_d = trig_event;
    case (state_q)
      IDLE: begin
        if (trig_event) begin
          acc_d   = step;
          state_d = DECAY;
        end else begin
          acc_d = '0;
        end
      end
      DECAY: begin
        // A pile-up event replaces that cycle's decay step.
        if (trig_event) begin
          acc_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
        end else if (decayed[W-1:FRAC_W] == '0) begin
          acc_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = decayed;
        end
      end
      default: begin
        acc_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      pulse_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      pulse_start_q <= pulse_start_d;
    end
  end

  assign bus.output_data = acc_q[W-1:FRAC_W];
  assign bus.pulse_start = pulse_start_q;
  assign bus.busy        = (state_q == DECAY);

endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Bench for adc_pulse_emulator: arithmetic reference model checked every cycle, plus directed
// literal expectations for the documented pulse shapes, pile-up, auto-trigger and reset cases.
module tb_adc_pulse_emulator;

  localparam int     DATA_W   = 12;
  localparam int     FRAC_W   = 8;
  localparam int     PERIOD_W = 16;
  localparam longint ACC_MAX  = (longint'(1) << (DATA_W + FRAC_W)) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  longint m_acc   = 0;
  int     m_cnt   = 0;
  bit     m_start = 1'b0;

  adc_pulse_emulator_if #(.DATA_W(DATA_W), .PERIOD_W(PERIOD_W)) ifc ();

  adc_pulse_emulator #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: busy is simply "accumulator non-zero"; one event per cycle adds the step, otherwise decay.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc   <= 0;
      m_cnt   <= 0;
      m_start <= 1'b0;
    end else begin : model_step
      longint acc_n;
      int     cnt_n;
      bit     fire;
      bit     ev;
      acc_n = m_acc;
      cnt_n = 0;
      fire  = 1'b0;
      if (ifc.enable && ifc.period != 0) begin
        if (m_cnt + 1 >= int'(ifc.period)) fire = 1'b1;
        else cnt_n = m_cnt + 1;
      end
      ev = (ifc.trig || fire) && ifc.enable && (ifc.amplitude != 0);
      if (ev) begin
        acc_n = m_acc + (longint'(ifc.amplitude) << FRAC_W);
        if (acc_n > ACC_MAX) acc_n = ACC_MAX;
      end else if (m_acc != 0) begin
        acc_n = m_acc - (m_acc >> ifc.decay_shift);
        if (acc_n < (longint'(1) << FRAC_W)) acc_n = 0;
      end
      m_acc   <= acc_n;
      m_cnt   <= cnt_n;
      m_start <= ev;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    tests_run++;
    if (actual !== 32'(expected)) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("model_data",  32'(ifc.output_data), int'(m_acc >> FRAC_W));
      checkOutput("model_start", 32'(ifc.pulse_start), int'(m_start));
      checkOutput("model_busy",  32'(ifc.busy),        (m_acc != 0) ? 1 : 0);
    end
  end

  // Drive one cycle of inputs from a negedge, return at the next negedge with trig cleared.
  task automatic applyStimulus(input bit trig, input int amp, input int shift, input bit en, input int per);
    ifc.trig        = trig;
    ifc.amplitude   = DATA_W'(amp);
    ifc.decay_shift = 4'(shift);
    ifc.enable      = en;
    ifc.period      = PERIOD_W'(per);
    @(negedge clk);
    ifc.trig = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int max_cycles);
    int n = 0;
    while (ifc.busy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(ifc.busy), 0);
  endtask

  initial begin
    int strobes;
    int first_strobe;
    int n;
    int r;
    int amp;
    int shift;
    int per;
    bit en;

    ifc.trig        = 1'b0;
    ifc.amplitude   = '0;
    ifc.decay_shift = 4'd2;
    ifc.enable      = 1'b0;
    ifc.period      = '0;

    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_data",  32'(ifc.output_data), 0);
    checkOutput("reset_busy",  32'(ifc.busy),        0);
    checkOutput("reset_start", 32'(ifc.pulse_start), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pulse, shift 2: 1000, 750, 562, 421, ...
    applyStimulus(1'b1, 1000, 2, 1'b1, 0);
    checkOutput("t1_s0_data",  32'(ifc.output_data), 1000);
    checkOutput("t1_s0_start", 32'(ifc.pulse_start), 1);
    checkOutput("t1_s0_busy",  32'(ifc.busy),        1);
    @(negedge clk);
    checkOutput("t1_s1_data",  32'(ifc.output_data), 750);
    checkOutput("t1_s1_start", 32'(ifc.pulse_start), 0);
    @(negedge clk);
    checkOutput("t1_s2_data",  32'(ifc.output_data), 562);
    @(negedge clk);
    checkOutput("t1_s3_data",  32'(ifc.output_data), 421);
    waitIdle("t1_idle", 100);
    checkOutput("t1_end_data", 32'(ifc.output_data), 0);

    // shift 0 empties the pulse in one cycle
    applyStimulus(1'b1, 500, 0, 1'b1, 0);
    checkOutput("t2_data", 32'(ifc.output_data), 500);
    checkOutput("t2_busy", 32'(ifc.busy),        1);
    @(negedge clk);
    checkOutput("t2_next_data", 32'(ifc.output_data), 0);
    checkOutput("t2_next_busy", 32'(ifc.busy),        0);

    // Back-to-back pile-up saturates
    applyStimulus(1'b1, 3000, 2, 1'b1, 0);
    checkOutput("t3_first", 32'(ifc.output_data), 3000);
    applyStimulus(1'b1, 3000, 2, 1'b1, 0);
    checkOutput("t3_sat",   32'(ifc.output_data), 4095);
    checkOutput("t3_start", 32'(ifc.pulse_start), 1);
    @(negedge clk);
    checkOutput("t3_decay", 32'(ifc.output_data), 3072);
    waitIdle("t3_idle", 200);

    // Zero amplitude is ignored
    applyStimulus(1'b1, 0, 2, 1'b1, 0);
    checkOutput("t5_data",  32'(ifc.output_data), 0);
    checkOutput("t5_start", 32'(ifc.pulse_start), 0);
    checkOutput("t5_busy",  32'(ifc.busy),        0);

    // Auto-trigger every 100 cycles, then disable mid-pulse
    ifc.amplitude   = DATA_W'(200);
    ifc.decay_shift = 4'd3;
    ifc.enable      = 1'b1;
    ifc.period      = PERIOD_W'(100);
    strobes      = 0;
    first_strobe = 0;
    for (int k = 1; k <= 305; k++) begin
      @(negedge clk);
      if (ifc.pulse_start === 1'b1) begin
        strobes++;
        if (first_strobe == 0) first_strobe = k;
      end
    end
    checkOutput("t4_first_strobe", 32'(first_strobe), 100);
    checkOutput("t4_strobes",      32'(strobes),      3);
    ifc.enable = 1'b0;
    @(negedge clk);
    checkOutput("t4_busy_after_disable", 32'(ifc.busy), 1);
    strobes = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifc.pulse_start === 1'b1) strobes++;
    end
    checkOutput("t4_strobes_disabled", 32'(strobes),  0);
    checkOutput("t4_idle",             32'(ifc.busy), 0);
    ifc.period = '0;

    // Asynchronous reset mid-decay
    applyStimulus(1'b1, 1000, 4, 1'b1, 0);
    n = 0;
    while (ifc.output_data > 620 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_reached_600", 32'(ifc.output_data <= 620), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_data", 32'(ifc.output_data), 0);
    checkOutput("t6_rst_busy", 32'(ifc.busy),        0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1000, 2, 1'b1, 0);
    checkOutput("t6_after_data",  32'(ifc.output_data), 1000);
    checkOutput("t6_after_start", 32'(ifc.pulse_start), 1);
    @(negedge clk);
    checkOutput("t6_after_next", 32'(ifc.output_data), 750);
    waitIdle("t6_idle", 100);

    // Randomized traffic against the model
    shift = 2;
    per   = 0;
    en    = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      amp = 0;
      else if (r < 3)  amp = int'($urandom_range(2000, 4095));
      else             amp = int'($urandom_range(1, 1500));
      if ($urandom_range(0, 31) == 0) shift = int'($urandom_range(0, 8));
      if ($urandom_range(0, 63) == 0) per = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
      if ($urandom_range(0, 99) == 0) en = ~en;
      applyStimulus($urandom_range(0, 7) == 0, amp, shift, en, per);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
